seg_capture_decoder: RTL and testbench

Receive-side counterpart of the BCD-to-seven-segment encoder. It samples a multiplexed, active-low seven-segment bus (segment pattern plus one-hot digit select) and decodes each stable pattern back to a 4-bit digit. Once every digit position has been captured, it publishes one packed frame with a single-cycle valid pulse. It is used to loop back and self-check display drivers and to read scanned displays from external boards.

---
 rtl/seg_capture_decoder.sv | 123 ++++++++++++
 tb/tb_seg_capture_decoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_capture_decoder.sv
// Samples a multiplexed active-low seven-segment bus, decodes each stable digit
// and publishes a packed frame once every digit position has been captured.
module seg_capture_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic                    frame_valid,
  output logic                    frame_err
);

  localparam int              CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   sel_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   done_q, done_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;

  logic       sel_onehot;
  logic       sample_same;
  logic       commit;
  logic [3:0] dec_val;
  logic       dec_err;

  // Pattern table; blank decodes to F without flagging an error.
  always_comb begin
    dec_val = 4'hE;
    dec_err = 1'b0;
    case (seg_q)
      7'b1000000:             dec_val = 4'd0;
      7'b1111001:             dec_val = 4'd1;
      7'b0100100:             dec_val = 4'd2;
      7'b0110000:             dec_val = 4'd3;
      7'b0011001:             dec_val = 4'd4;
      7'b0010010:             dec_val = 4'd5;
      7'b0000010:             dec_val = 4'd6;
      7'b1011000, 7'b1111000: dec_val = 4'd7;
      7'b0000000:             dec_val = 4'd8;
      7'b0010000:             dec_val = 4'd9;
      7'b1111111:             dec_val = 4'hF;
      default: begin
        dec_val = 4'hE;
        dec_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    sel_onehot  = $onehot(sel_q);
    sample_same = (seg_in == seg_q) && (dig_sel == sel_q);

    if (!sel_onehot)              cnt_d = '0;
    else if (sample_same)         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    else                          cnt_d = CNT_ONE;

    // Only the edge that reaches the threshold commits; saturation blocks repeats.
    commit = (cnt_q == CNT_MAX - CNT_ONE) && (cnt_d == CNT_MAX);

    shadow_d = shadow_q;
    done_d   = done_q;
    err_d    = err_q;
    digits_d = digits_q;
    ferr_d   = ferr_q;
    valid_d  = 1'b0;

    if (commit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_q[i]) begin
          shadow_d[4*i +: 4] = dec_val;
          done_d[i]          = 1'b1;
          err_d[i]           = dec_err;
        end
      end
      if (&done_d) begin
        digits_d = shadow_d;
        ferr_d   = |err_d;
        valid_d  = 1'b1;
        done_d   = '0;
        err_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= 7'h7F;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      done_q   <= '0;
      err_q    <= '0;
      digits_q <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      seg_q    <= seg_in;
      sel_q    <= dig_sel;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
      err_q    <= err_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  assign digits_out  = digits_q;
  assign frame_valid = valid_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Directed and randomized bench for seg_capture_decoder, checked every cycle
// against a frame-level reference model of the capture rules.
module tb_seg_capture_decoder;

  localparam int N = 4;
  localparam int S = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [6:0]   seg_in;
  logic [N-1:0] dig_sel;
  logic [W-1:0] digits_out;
  logic         frame_valid;
  logic         frame_err;

  always #5 clk = ~clk;

  seg_capture_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .digits_out  (digits_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Legal digit glyphs; entries 7 and 8 are the two accepted forms of 7.
  logic [6:0] pats [11] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b1011000, 7'b0000000, 7'b0010000};
  int         vals [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 8, 9};

  // Reference model state
  logic [6:0]   m_prev_seg;
  logic [N-1:0] m_prev_sel;
  int           m_run;
  logic [3:0]   m_shadow [N];
  logic         m_done   [N];
  logic         m_err    [N];
  logic [W-1:0] m_digits;
  logic         m_ferr;
  logic         m_valid;

  logic [W:0] exp_q [$];
  int         pulse_q [$];
  int         pulse_ok, pulse_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    if (d <= 7)      seg_of = pats[d];
    else if (d == 8) seg_of = pats[9];
    else             seg_of = pats[10];
  endfunction

  function automatic logic [N-1:0] sel_of(input int s);
    sel_of    = '0;
    sel_of[s] = 1'b1;
  endfunction

  function automatic void decode(input logic [6:0] p, output logic [3:0] v, output logic e);
    v = 4'hE;
    e = 1'b1;
    if (p == 7'h7F) begin
      v = 4'hF;
      e = 1'b0;
    end
    for (int k = 0; k < 11; k++) begin
      if (pats[k] == p) begin
        v = 4'(vals[k]);
        e = 1'b0;
      end
    end
  endfunction

  task automatic model_reset();
    m_prev_seg = 7'h7F;
    m_prev_sel = '0;
    m_run      = 0;
    for (int k = 0; k < N; k++) begin
      m_shadow[k] = 4'h0;
      m_done[k]   = 1'b0;
      m_err[k]    = 1'b0;
    end
    m_digits = '0;
    m_ferr   = 1'b0;
    m_valid  = 1'b0;
  endtask

  // One rising edge of the model: a run of identical samples on a legal select
  // commits once, when it first reaches S.
  task automatic model_edge(input logic [6:0] seg, input logic [N-1:0] sel);
    int         new_run;
    int         slot;
    logic [3:0] v;
    logic       e;
    bit         all_done;
    if ($countones(m_prev_sel) != 1)                   new_run = 0;
    else if (seg == m_prev_seg && sel == m_prev_sel)   new_run = (m_run < S) ? m_run + 1 : S;
    else                                               new_run = 1;
    m_valid = 1'b0;
    if (m_run == S - 1 && new_run == S) begin
      slot = 0;
      for (int k = 0; k < N; k++) if (m_prev_sel[k]) slot = k;
      decode(m_prev_seg, v, e);
      m_shadow[slot] = v;
      m_done[slot]   = 1'b1;
      m_err[slot]    = e;
      all_done = 1'b1;
      for (int k = 0; k < N; k++) all_done &= m_done[k];
      if (all_done) begin
        m_ferr = 1'b0;
        for (int k = 0; k < N; k++) begin
          m_digits[4*k +: 4] = m_shadow[k];
          m_ferr            |= m_err[k];
          m_done[k]          = 1'b0;
          m_err[k]           = 1'b0;
        end
        m_valid = 1'b1;
        exp_q.push_back({m_ferr, m_digits});
      end
    end
    m_prev_seg = seg;
    m_prev_sel = sel;
    m_run      = new_run;
  endtask

  task automatic check_outputs();
    logic [W:0] e;
    chk("frame_valid", frame_valid, m_valid);
    chk("digits_out", digits_out, m_digits);
    chk("frame_err", frame_err, m_ferr);
    if (m_valid) begin
      e = exp_q.pop_front();
      chk("frame_content", {frame_err, digits_out}, e);
    end
    if (frame_valid === 1'b1) begin
      pulse_q.push_back(cyc);
      if (frame_err) pulse_bad++;
      else           pulse_ok++;
    end
  endtask

  task automatic tick(input logic [6:0] seg, input logic [N-1:0] sel);
    seg_in  = seg;
    dig_sel = sel;
    @(posedge clk);
    cyc++;
    model_edge(seg, sel);
    #1;
    check_outputs();
  endtask

  task automatic hold(input logic [6:0] seg, input logic [N-1:0] sel, input int n);
    for (int i = 0; i < n; i++) tick(seg, sel);
  endtask

  task automatic scan(input logic [W-1:0] v, input int first_dwell);
    for (int k = 0; k < N; k++)
      hold(seg_of(int'(v[4*k +: 4])), sel_of(k), (k == 0) ? first_dwell : S);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_digits", digits_out, 0);
    chk("rst_valid", frame_valid, 0);
    chk("rst_err", frame_err, 0);
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_digits", digits_out, 0);
    chk("rst_hold_valid", frame_valid, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int         pc;
    int         slot;
    int         dw;
    logic [6:0] p;

    rst_n   = 1'b0;
    seg_in  = 7'h7F;
    dig_sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_digits", digits_out, 0);
    chk("init_valid", frame_valid, 0);
    chk("init_err", frame_err, 0);
    rst_n = 1'b1;

    // Mid-run reset discards a partial frame and clears published outputs.
    scan(16'h7531, S + 1);
    hold(seg_of(9), sel_of(0), S);
    hold(seg_of(9), sel_of(1), 2);
    do_reset();
    pc = pulse_q.size();
    scan(16'h4321, S + 1);
    chk("reset_scan_pulses", pulse_q.size() - pc, 1);
    chk("reset_scan_digits", digits_out, 16'h4321);
    chk("reset_scan_err", frame_err, 0);

    // Stability: a 3-cycle hold never commits; a 20-cycle hold commits once.
    pc = pulse_q.size();
    hold(seg_of(5), sel_of(0), S - 1);
    hold(seg_of(6), sel_of(1), S);
    hold(seg_of(7), sel_of(2), S);
    hold(seg_of(8), sel_of(3), S);
    chk("short_hold_no_frame", pulse_q.size() - pc, 0);
    hold(seg_of(5), sel_of(0), S);
    chk("stable_slot0", digits_out, 16'h8765);
    hold(seg_of(1), sel_of(1), S);
    hold(seg_of(2), sel_of(2), S);
    hold(seg_of(3), sel_of(3), S);
    hold(seg_of(4), sel_of(0), 20);
    hold(seg_of(1), sel_of(1), S);
    hold(seg_of(2), sel_of(2), S);
    hold(seg_of(3), sel_of(3), S);
    chk("long_hold_one_commit", pulse_q.size() - pc, 2);
    hold(seg_of(0), sel_of(0), S);
    chk("long_hold_pulses", pulse_q.size() - pc, 3);

    // Overwrite of an already-captured slot before completion.
    pc = pulse_q.size();
    hold(seg_of(3), sel_of(1), S);
    hold(seg_of(8), sel_of(1), S);
    hold(seg_of(6), sel_of(0), S);
    hold(seg_of(2), sel_of(2), S);
    hold(seg_of(9), sel_of(3), S);
    chk("overwrite_pulses", pulse_q.size() - pc, 1);
    chk("overwrite_digits", digits_out, 16'h9286);

    // Illegal selects commit nothing and leave the partial frame intact.
    pc = pulse_q.size();
    hold(seg_of(1), sel_of(0), S);
    hold(seg_of(7), sel_of(1), S);
    hold(seg_of(5), 4'b0000, 10);
    hold(seg_of(5), 4'b0110, 10);
    chk("illegal_no_frame", pulse_q.size() - pc, 0);
    hold(seg_of(4), sel_of(2), S + 1);
    hold(seg_of(0), sel_of(3), S);
    chk("illegal_pulses", pulse_q.size() - pc, 1);
    chk("illegal_digits", digits_out, 16'h0471);

    // Decode sweep of every pattern on digit 0.
    pulse_ok  = 0;
    pulse_bad = 0;
    for (int pat = 0; pat < 128; pat++) begin
      hold(seg_of(1), sel_of(1), S);
      hold(seg_of(2), sel_of(2), S);
      hold(seg_of(3), sel_of(3), S);
      hold(7'(pat), sel_of(0), S);
    end
    chk("sweep_clean_frames", pulse_ok, 12);
    chk("sweep_err_frames", pulse_bad, 116);

    // Back-to-back frames at minimum dwell.
    pc = pulse_q.size();
    scan(16'h1234, S);
    scan(16'h5678, S);
    scan(16'h9012, S);
    chk("b2b_pulses", pulse_q.size() - pc, 3);
    if (pulse_q.size() - pc == 3) begin
      chk("b2b_gap1", pulse_q[pc + 1] - pulse_q[pc], N * S);
      chk("b2b_gap2", pulse_q[pc + 2] - pulse_q[pc + 1], N * S);
    end
    chk("b2b_digits", digits_out, 16'h9012);

    // Randomized legal traffic with short glitches and undecodable patterns.
    for (int r = 0; r < 60; r++) begin
      slot = $urandom_range(N - 1, 0);
      if ($urandom_range(9, 0) < 7) p = seg_of($urandom_range(9, 0));
      else                          p = 7'($urandom_range(127, 0));
      dw = $urandom_range(6, 1);
      hold(p, sel_of(slot), dw);
    end
    scan(16'h2468, S);
    do_reset();
    scan(16'h1357, S + 1);
    chk("final_digits", digits_out, 16'h1357);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
